// File: rtl/msg_sender.sv
// Transmit side of the count/msg_rdy link: sends a latched message one word per
// count_out strobe, then waits for the receiver's msg_rdy or times out.
module msg_sender #(
    parameter int WORD_W    = 8,
    parameter int MSG_WORDS = 3,
    parameter int GAP_CYC   = 1,
    parameter int ACK_TO    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [MSG_WORDS*WORD_W-1:0] msg_in,
    input  logic                        msg_rdy,
    output logic [WORD_W-1:0]           word_out,
    output logic                        count_out,
    output logic                        rx_clr,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int IDX_W = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int TO_W  = $clog2(ACK_TO + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_WORDS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TO - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_SETUP, S_STROBE, S_GAP, S_WAIT, S_DONE, S_ERR
    } state_t;

    state_t                      r_state;
    logic [MSG_WORDS*WORD_W-1:0] r_msg;
    logic [IDX_W-1:0]            r_idx;
    logic [GAP_W-1:0]            r_gap;
    logic [TO_W-1:0]             r_to;
    logic                        r_sync1, r_sync2;
    logic [WORD_W-1:0]           r_word;
    logic                        r_count, r_rx_clr, r_busy, r_done, r_err;

    // Outputs are registered alongside the state they belong to, so each
    // output reflects the current state with no combinational decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_msg    <= '0;
            r_idx    <= '0;
            r_gap    <= '0;
            r_to     <= '0;
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_word   <= '0;
            r_count  <= 1'b0;
            r_rx_clr <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_sync1  <= msg_rdy;
            r_sync2  <= r_sync1;
            r_count  <= 1'b0;
            r_rx_clr <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_msg    <= msg_in;
                    r_idx    <= '0;
                    r_busy   <= 1'b1;
                    r_err    <= 1'b0;
                    r_rx_clr <= 1'b1;
                    r_state  <= S_CLR;
                end
                // The message register shifts down so word 0 is always at the bottom.
                S_CLR: begin
                    r_word  <= r_msg[WORD_W-1:0];
                    r_msg   <= r_msg >> WORD_W;
                    r_state <= S_SETUP;
                end
                S_SETUP: begin
                    r_count <= 1'b1;
                    r_state <= S_STROBE;
                end
                S_STROBE: begin
                    r_gap   <= '0;
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        if (r_idx == IDX_LAST) begin
                            r_to    <= '0;
                            r_state <= S_WAIT;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_word  <= r_msg[WORD_W-1:0];
                            r_msg   <= r_msg >> WORD_W;
                            r_state <= S_SETUP;
                        end
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                // Ack is checked before the timeout so a late ack still wins.
                S_WAIT: begin
                    if (r_sync2) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_to == TO_LAST) begin
                        r_err    <= 1'b1;
                        r_rx_clr <= 1'b1;
                        r_state  <= S_ERR;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign word_out  = r_word;
    assign count_out = r_count;
    assign rx_clr    = r_rx_clr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_msg_sender.sv
// Directed bench for msg_sender: default instance with a model receiver, plus a
// single-word / long-gap instance.
module tb_msg_sender;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---- instance A: defaults (8-bit, 3 words, gap 1, timeout 16)
    logic        start_a = 1'b0;
    logic [23:0] msg_in_a = '0;
    logic        msg_rdy_a;
    logic [7:0]  word_a;
    logic        co_a, rc_a, bz_a, dn_a, er_a;
    logic        frc_en = 1'b0, frc_v = 1'b0, rdy_a = 1'b0;
    int          cnt_a = 0;

    msg_sender dut_a (
        .clk(clk), .rst(rst), .start(start_a), .msg_in(msg_in_a), .msg_rdy(msg_rdy_a),
        .word_out(word_a), .count_out(co_a), .rx_clr(rc_a), .busy(bz_a), .done(dn_a), .err(er_a)
    );

    // ---- instance B: 4-bit, 1 word, gap 3
    logic       start_b = 1'b0;
    logic [3:0] msg_in_b = '0;
    logic       msg_rdy_b;
    logic [3:0] word_b;
    logic       co_b, rc_b, bz_b, dn_b, er_b;
    logic       rdy_b = 1'b0;
    int         cnt_b = 0;

    msg_sender #(.WORD_W(4), .MSG_WORDS(1), .GAP_CYC(3), .ACK_TO(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .msg_in(msg_in_b), .msg_rdy(msg_rdy_b),
        .word_out(word_b), .count_out(co_b), .rx_clr(rc_b), .busy(bz_b), .done(dn_b), .err(er_b)
    );

    // Receiver models: count strobes, cleared by rx_clr, raise msg_rdy at terminal count.
    always @(negedge clk) begin
        if (rst || rc_a) cnt_a = 0;
        else if (co_a) cnt_a = cnt_a + 1;
        rdy_a = (cnt_a == 3);
        if (rst || rc_b) cnt_b = 0;
        else if (co_b) cnt_b = cnt_b + 1;
        rdy_b = (cnt_b == 1);
    end
    assign msg_rdy_a = frc_en ? frc_v : rdy_a;
    assign msg_rdy_b = rdy_b;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-cycle record of instance A; cycle 0 is the IDLE cycle where start is sampled.
    logic [63:0] m_co, m_rc, m_dn, m_er, m_bz;
    logic [7:0]  wo [0:63];

    task automatic rec(input int c);
        m_co[c] = co_a; m_rc[c] = rc_a; m_dn[c] = dn_a;
        m_er[c] = er_a; m_bz[c] = bz_a; wo[c] = word_a;
    endtask

    task automatic run_a(input int len, input bit hold, input bit noise,
                         input logic [23:0] m1, input logic [23:0] m2);
        m_co = '0; m_rc = '0; m_dn = '0; m_er = '0; m_bz = '0;
        @(negedge clk);
        msg_in_a = m1;
        start_a  = 1'b1;
        rec(0);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            rec(c);
            if (c == 1) begin
                msg_in_a = m2;
                start_a  = hold;
            end
            if (noise) begin
                if (c >= 2 && c <= 8) begin
                    start_a = c[0];
                    frc_en  = 1'b1;
                    frc_v   = ~c[0];
                end else begin
                    start_a = hold;
                    frc_en  = 1'b0;
                end
            end
        end
    endtask

    int          nco;
    logic [63:0] mb_co, mb_dn;
    logic [3:0]  wob [0:15];
    logic        bzb9;

    initial begin
        // Reset state
        #12;
        chk("reset_outs_a", {word_a, co_a, rc_a, bz_a, dn_a, er_a}, 64'h0);
        chk("reset_outs_b", {word_b, co_b, rc_b, bz_b, dn_b, er_b}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Basic send; msg_in scribbled after acceptance
        run_a(14, 1'b0, 1'b0, 24'hC3_B2_A1, 24'hFF_FF_FF);
        chk("basic_rx_clr", m_rc, 64'h2);
        chk("basic_strobes", m_co, (64'h1 << 3) | (64'h1 << 6) | (64'h1 << 9));
        chk("basic_w0_setup", wo[2], 8'hA1);
        chk("basic_w0_strobe", wo[3], 8'hA1);
        chk("basic_w0_gap", wo[4], 8'hA1);
        chk("basic_w1_strobe", wo[6], 8'hB2);
        chk("basic_w2_strobe", wo[9], 8'hC3);
        chk("basic_done", m_dn, 64'h1 << 12);
        chk("basic_busy", m_bz[14:0], 15'b001_1111_1111_1110);
        chk("basic_err", m_er, 64'h0);

        // Timeout with msg_rdy held low
        frc_en = 1'b1; frc_v = 1'b0;
        run_a(29, 1'b0, 1'b0, 24'h03_02_01, 24'hFF_FF_FF);
        frc_en = 1'b0;
        chk("to_err_edge", m_er[28:26], 3'b110);
        chk("to_rx_clr", m_rc, (64'h1 << 1) | (64'h1 << 27));
        chk("to_busy", m_bz[28:26], 3'b011);
        chk("to_no_done", m_dn, 64'h0);

        // Ignored inputs while sending; also err clears on accepted start
        run_a(14, 1'b0, 1'b1, 24'h66_55_44, 24'h66_55_44);
        chk("ign_err_before", m_er[0], 1'b1);
        chk("ign_err_clear", m_er[1], 1'b0);
        chk("ign_strobes", m_co, (64'h1 << 3) | (64'h1 << 6) | (64'h1 << 9));
        chk("ign_rx_clr", m_rc, 64'h2);
        chk("ign_done", m_dn, 64'h1 << 12);
        chk("ign_w2", wo[9], 8'h66);

        // Back-to-back with start held high
        run_a(25, 1'b1, 1'b0, 24'h13_12_11, 24'h23_22_21);
        start_a = 1'b0;
        chk("b2b_rx_clr", m_rc, (64'h1 << 1) | (64'h1 << 14));
        chk("b2b_strobes", m_co, (64'h1 << 3) | (64'h1 << 6) | (64'h1 << 9) |
                                 (64'h1 << 16) | (64'h1 << 19) | (64'h1 << 22));
        chk("b2b_done", m_dn, (64'h1 << 12) | (64'h1 << 25));
        chk("b2b_idle_gap", m_bz[14:12], 3'b101);
        chk("b2b_m1_w2", wo[9], 8'h13);
        chk("b2b_m2_w0", wo[16], 8'h21);
        chk("b2b_m2_w2", wo[22], 8'h23);
        repeat (3) @(negedge clk);

        // Reset mid-GAP of word 1
        run_a(7, 1'b0, 1'b0, 24'hC3_B2_A1, 24'hFF_FF_FF);
        chk("rst_pre_strobes", m_co, (64'h1 << 3) | (64'h1 << 6));
        chk("rst_pre_word", wo[7], 8'hB2);
        rst = 1'b1;
        #1;
        chk("rst_async_outs", {word_a, co_a, rc_a, bz_a, dn_a, er_a}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        nco = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (co_a || bz_a || dn_a || rc_a) nco++;
        end
        chk("rst_quiet_after", nco, 0);

        // Single-word, long-gap instance
        mb_co = '0; mb_dn = '0;
        @(negedge clk);
        msg_in_b = 4'h9;
        start_b  = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start_b  = 1'b0;
                msg_in_b = 4'h6;
            end
            mb_co[c] = co_b;
            mb_dn[c] = dn_b;
            wob[c]   = word_b;
            bzb9     = bz_b;
        end
        chk("b_strobe", mb_co, 64'h1 << 3);
        for (int c = 2; c <= 6; c++) chk("b_word_stable", wob[c], 4'h9);
        chk("b_done", mb_dn, 64'h1 << 8);
        chk("b_busy_end", bzb9, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
